// File: rtl/key_cursor.sv
// Pushbutton front end for the position game: synchronise, debounce and edge-detect
// four active-low buttons, then steer a wrapping 3-bit cursor and a confirm/hold handshake.
module key_cursor #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned CNT_W           = 19,
  parameter int unsigned POS_MAX         = 7
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       switch,
  input  logic [3:0] button4,
  output logic [2:0] pos,
  output logic [3:0] key_state,
  output logic [3:0] press,
  output logic       confirm,
  output logic       busy
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACTIVE = 2'd1;
  localparam logic [1:0] HOLD   = 2'd2;

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [2:0]       POS_LAST  = 3'(POS_MAX);

  localparam int BTN_RIGHT   = 0;
  localparam int BTN_LEFT    = 1;
  localparam int BTN_HOME    = 2;
  localparam int BTN_CONFIRM = 3;

  logic [3:0]            sync1_q, sync2_q;
  logic [3:0]            key_q, key_d;
  logic [3:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]            press_q, press_d;
  logic [1:0]            state_q, state_d;
  logic [2:0]            pos_q, pos_d;
  logic                  confirm_q, confirm_d;

  // Counter runs only while the synchronised level disagrees with the stable level.
  always_comb begin
    key_d = key_q;
    cnt_d = cnt_q;
    for (int i = 0; i < 4; i++) begin
      if (sync2_q[i] == key_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_LAST) begin
        key_d[i] = sync2_q[i];
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
    press_d = key_q & ~key_d;
  end

  always_comb begin
    state_d   = state_q;
    pos_d     = pos_q;
    confirm_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (switch) begin
          state_d = ACTIVE;
          pos_d   = 3'd0;
        end
      end
      ACTIVE: begin
        if (!switch) begin
          state_d = IDLE;
        end else begin
          if (press_q[BTN_HOME]) begin
            pos_d = 3'd0;
          end else if (press_q[BTN_RIGHT] && !press_q[BTN_LEFT]) begin
            pos_d = (pos_q == POS_LAST) ? 3'd0 : pos_q + 3'd1;
          end else if (press_q[BTN_LEFT] && !press_q[BTN_RIGHT]) begin
            pos_d = (pos_q == 3'd0) ? POS_LAST : pos_q - 3'd1;
          end
          if (press_q[BTN_CONFIRM]) begin
            confirm_d = 1'b1;
            state_d   = HOLD;
          end
        end
      end
      HOLD: begin
        // Leave HOLD only once every button is seen released.
        if (!switch) begin
          state_d = IDLE;
        end else if (key_q == 4'b1111) begin
          state_d = ACTIVE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      sync1_q   <= 4'b1111;
      sync2_q   <= 4'b1111;
      key_q     <= 4'b1111;
      cnt_q     <= '0;
      press_q   <= 4'b0000;
      state_q   <= IDLE;
      pos_q     <= 3'd0;
      confirm_q <= 1'b0;
    end else begin
      sync1_q   <= button4;
      sync2_q   <= sync1_q;
      key_q     <= key_d;
      cnt_q     <= cnt_d;
      press_q   <= press_d;
      state_q   <= state_d;
      pos_q     <= pos_d;
      confirm_q <= confirm_d;
    end
  end

  assign pos       = pos_q;
  assign key_state = key_q;
  assign press     = press_q;
  assign confirm   = confirm_q;
  assign busy      = (state_q == HOLD);

endmodule
